alu_decode_stage: RTL
=====================

Name: alu_decode_stage

Overview:
- Registered RV32I decode stage that produces every control input of the core ALU: op, sign, b_add_one, b_negate and operand selects.
- Accepts fetched instructions over a valid/ready handshake and holds one decoded entry in an output pipeline register.
- Sits between fetch and execute and drives the ALU operand muxes, immediate path, register-file write enable and branch resolution.

Parameters:
WIDTH, 32, datapath and PC width; immediates sign-extended to WIDTH.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage can accept
in_instr  input  32  instruction word
in_pc  input  WIDTH  instruction PC
flush  input  1  discard held entry (redirect)
out_valid  output  1  decoded entry valid
out_ready  input  1  execute accepts entry
out_pc  output  WIDTH  registered PC
out_alu_op  output  3  000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 shift-right, 110 or, 111 and
out_alu_sign  output  1  arithmetic right shift
out_alu_b_negate  output  1  invert operand B
out_alu_b_add_one  output  1  add 1 to operand B
out_a_sel  output  2  0 rs1, 1 pc, 2 zero
out_b_sel  output  2  0 rs2, 1 imm, 2 constant 4
out_imm  output  WIDTH  decoded immediate
out_rs1, out_rs2, out_rd  output  5 each  register indices
out_reg_we  output  1  writeback enable
out_mem_read, out_mem_write  output  1 each  load/store
out_funct3  output  3  instr[14:12] passthrough (mem size, branch kind)
out_br_kind  output  2  0 none, 1 taken if zero_flag, 2 taken if result[0]
out_br_invert  output  1  invert branch condition
out_jump  output  1  JAL/JALR

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. On reset, out_valid=0 and every registered output is 0.
- Handshake: in_ready = !flush && (!out_valid || out_ready). A transfer happens when in_valid && in_ready; decoded fields load on that edge. Latency is 1 cycle.
- out_valid updates each cycle:
  - flush → 0. Flush has priority; no input is accepted in a flush cycle.
  - Else transfer → 1.
  - Else out_ready → 0.
  - Else hold. Outputs stay stable while out_valid && !out_ready.
- Decode by opcode:
  - OP: funct3 maps directly to alu_op. funct7=0100000 with funct3 000 (SUB) sets negate=1 and add_one=1. With funct3 101 (SRA) it sets sign=1. Selects a=rs1, b=rs2.
  - OP-IMM: same mapping, b=imm, never negate. SLLI/SRLI/SRAI drive out_imm = zero-extended instr[24:20]; funct7 must not leak into the shift amount. SRAI sets sign=1.
  - LUI: a=zero, b=imm, add, U-imm.
  - AUIPC: a=pc, b=imm, add.
  - JAL, JALR: a=pc, b=4, add, jump=1, reg_we. out_imm is the J-imm or I-imm respectively.
  - LOAD: a=rs1, b=imm, add, mem_read, reg_we.
  - STORE: a=rs1, b=imm, add, mem_write, S-imm.
  - BRANCH: B-imm, a=rs1, b=rs2, reg_we=0.
    - BEQ/BNE: add with negate=1 and add_one=1, br_kind=1; BNE sets invert.
    - BLT/BGE: slt, br_kind=2; BGE sets invert.
    - BLTU/BGEU: sltu, br_kind=2; BGEU sets invert.
  - MISC-MEM (FENCE): NOP.
- reg_we is forced 0 when rd=0.
- Illegal encodings decode as NOP: all enables and br_kind 0, alu add, valid entry still issued. Illegal means:
  - instr[1:0]≠11 or unknown opcode;
  - bad funct7 on OP, SLLI, SRLI/SRAI;
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 >010;
  - SYSTEM.

Optional Feature:
- Macro ILLEGAL_INSTR_TRAP_EN.
- When defined: adds output out_illegal (1 bit, registered, reset 0), set with the NOP decode for any illegal encoding.
- When undefined: the port is absent and illegal encodings are silent NOPs.

Decomposition:
- Package riscv_pkg: opcode constants, alu_op_t enum matching the 3-bit ALU encoding, a_sel_t, b_sel_t, br_kind_t, decoded-entry struct.
- Sub-module imm_gen: combinational, instruction → I/S/B/U/J immediate plus shamt form, WIDTH sign-extension.

Test Plan:
- 0x402081B3 (sub x3,x1,x2) with out_ready=1 → next cycle out_valid=1, alu_op=000, negate=1, add_one=1, a_sel=0, b_sel=0, rd=3, reg_we=1.
- 0x40335293 (srai x5,x6,3) → alu_op=101, sign=1, b_sel=1, out_imm=3 (not 0x403).
- 0xFE209EE3 (bne x1,x2,-4) → out_imm=0xFFFFFFFC, br_kind=1, br_invert=1, negate=1, add_one=1, reg_we=0.
- 0x123453B7 (lui x7,0x12345) → a_sel=2, b_sel=1, out_imm=0x12345000, rd=7; 0x00000013 (addi x0,x0,0) → reg_we=0.
- Backpressure: two back-to-back instructions, out_ready=0 → in_ready=0 after the first, outputs held; raise out_ready → second issued next cycle. Assert flush while out_valid=1 → out_valid=0 next cycle. Drop rst_n mid-stall → out_valid=0 immediately.
- 0x00000000 → NOP entry (reg_we=0, mem 0, br_kind 0); with ILLEGAL_INSTR_TRAP_EN, out_illegal=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes and decode-stage types.
// Shared by alu_decode_stage and imm_gen.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_ZERO = 2'd1,
    BR_RES0 = 2'd2
  } br_kind_t;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_B  = 3'd2,
    IMM_U  = 3'd3,
    IMM_J  = 3'd4,
    IMM_SH = 3'd5
  } imm_sel_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_sign;
    logic       b_negate;
    logic       b_add_one;
    a_sel_t     a_sel;
    b_sel_t     b_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_we;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    br_kind_t   br_kind;
    logic       br_invert;
    logic       jump;
  } dec_t;

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// imm_gen: RV32I immediate extraction (I/S/B/U/J and shamt),
// sign-extended to WIDTH.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:7]      i_instr,
  input  imm_sel_t         i_sel,
  output logic [WIDTH-1:0] o_imm
);

  logic signed [31:0] w_raw;

  // pick the immediate layout for the current format
  always_comb begin
    w_raw = '0;
    unique case (i_sel)
      IMM_I:  w_raw = {{20{i_instr[31]}},
                       i_instr[31:20]};
      IMM_S:  w_raw = {{20{i_instr[31]}},
                       i_instr[31:25], i_instr[11:7]};
      IMM_B:  w_raw = {{19{i_instr[31]}},
                       i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8],
                       1'b0};
      IMM_U:  w_raw = {i_instr[31:12], 12'b0};
      IMM_J:  w_raw = {{11{i_instr[31]}},
                       i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21],
                       1'b0};
      IMM_SH: w_raw = {27'b0, i_instr[24:20]};
      default: w_raw = '0;
    endcase
  end

  assign o_imm = WIDTH'(w_raw);

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I decode producing ALU controls.
// Define ILLEGAL_INSTR_TRAP_EN to add the out_illegal flag.
module alu_decode_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [2:0]       out_alu_op,
  output logic             out_alu_sign,
  output logic             out_alu_b_negate,
  output logic             out_alu_b_add_one,
  output logic [1:0]       out_a_sel,
  output logic [1:0]       out_b_sel,
  output logic [WIDTH-1:0] out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_reg_we,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [2:0]       out_funct3,
  output logic [1:0]       out_br_kind,
  output logic             out_br_invert,
  output logic             out_jump
`ifdef ILLEGAL_INSTR_TRAP_EN
  ,
  output logic             out_illegal
`endif
);

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic             w_xfer;
  logic             w_bad;
  imm_sel_t         w_isel;
  dec_t             w_dec;
  logic [WIDTH-1:0] w_imm;

  logic             r_valid;
  dec_t             r_dec;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_imm;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];

  assign in_ready = !flush && (!r_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;

  imm_gen #(.WIDTH(WIDTH)) u_imm (
    .i_instr (in_instr[31:7]),
    .i_sel   (w_isel),
    .o_imm   (w_imm)
  );

  // opcode decode; anything unrecognised collapses to a NOP
  always_comb begin
    w_dec  = '0;
    w_isel = IMM_I;
    w_bad  = 1'b0;
    unique case (1'b1)
      (w_opc == OPC_OP): begin
        w_dec.alu_op = alu_op_t'(w_f3);
        w_dec.reg_we = 1'b1;
        if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
          w_dec.b_negate  = 1'b1;
          w_dec.b_add_one = 1'b1;
        end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
          w_dec.alu_sign = 1'b1;
        end else if (w_f7 != F7_ZERO) begin
          w_bad = 1'b1;
        end
      end
      (w_opc == OPC_OP_IMM): begin
        w_dec.alu_op = alu_op_t'(w_f3);
        w_dec.b_sel  = B_IMM;
        w_dec.reg_we = 1'b1;
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_isel = IMM_SH;
          if (w_f7 == F7_ALT && w_f3 == 3'b101)
            w_dec.alu_sign = 1'b1;
          else if (w_f7 != F7_ZERO)
            w_bad = 1'b1;
        end
      end
      (w_opc == OPC_LUI): begin
        w_isel       = IMM_U;
        w_dec.a_sel  = A_ZERO;
        w_dec.b_sel  = B_IMM;
        w_dec.reg_we = 1'b1;
      end
      (w_opc == OPC_AUIPC): begin
        w_isel       = IMM_U;
        w_dec.a_sel  = A_PC;
        w_dec.b_sel  = B_IMM;
        w_dec.reg_we = 1'b1;
      end
      (w_opc == OPC_JAL),
      (w_opc == OPC_JALR): begin
        w_isel       = w_opc[3] ? IMM_J : IMM_I;
        w_dec.a_sel  = A_PC;
        w_dec.b_sel  = B_FOUR;
        w_dec.jump   = 1'b1;
        w_dec.reg_we = 1'b1;
      end
      (w_opc == OPC_LOAD): begin
        w_dec.b_sel    = B_IMM;
        w_dec.mem_read = 1'b1;
        w_dec.reg_we   = 1'b1;
        w_bad = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      (w_opc == OPC_STORE): begin
        w_isel          = IMM_S;
        w_dec.b_sel     = B_IMM;
        w_dec.mem_write = 1'b1;
        w_bad = w_f3[2] || (w_f3 == 3'b011);
      end
      (w_opc == OPC_BRANCH): begin
        w_isel          = IMM_B;
        w_dec.br_invert = w_f3[0];
        case (w_f3[2:1])
          2'b00: begin
            w_dec.b_negate  = 1'b1;
            w_dec.b_add_one = 1'b1;
            w_dec.br_kind   = BR_ZERO;
          end
          2'b10: begin
            w_dec.alu_op  = ALU_SLT;
            w_dec.br_kind = BR_RES0;
          end
          2'b11: begin
            w_dec.alu_op  = ALU_SLTU;
            w_dec.br_kind = BR_RES0;
          end
          default: w_bad = 1'b1;
        endcase
      end
      (w_opc == OPC_FENCE): begin
        w_dec = '0;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad)
      w_dec = '0;
    w_dec.rs1    = in_instr[19:15];
    w_dec.rs2    = in_instr[24:20];
    w_dec.rd     = in_instr[11:7];
    w_dec.funct3 = w_f3;
    w_dec.reg_we = w_dec.reg_we && (in_instr[11:7] != 5'd0);
  end

  // output pipeline register and its valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
    end else begin
      if (flush)
        r_valid <= 1'b0;
      else if (w_xfer)
        r_valid <= 1'b1;
      else if (out_ready)
        r_valid <= 1'b0;
      if (w_xfer) begin
        r_dec <= w_dec;
        r_pc  <= in_pc;
        r_imm <= w_imm;
      end
    end
  end

`ifdef ILLEGAL_INSTR_TRAP_EN
  logic r_illegal;

  // illegal flag travels with the NOP entry it marks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal <= 1'b0;
    else if (w_xfer)
      r_illegal <= w_bad;
  end

  assign out_illegal = r_illegal;
`endif

  assign out_valid         = r_valid;
  assign out_pc            = r_pc;
  assign out_imm           = r_imm;
  assign out_alu_op        = r_dec.alu_op;
  assign out_alu_sign      = r_dec.alu_sign;
  assign out_alu_b_negate  = r_dec.b_negate;
  assign out_alu_b_add_one = r_dec.b_add_one;
  assign out_a_sel         = r_dec.a_sel;
  assign out_b_sel         = r_dec.b_sel;
  assign out_rs1           = r_dec.rs1;
  assign out_rs2           = r_dec.rs2;
  assign out_rd            = r_dec.rd;
  assign out_reg_we        = r_dec.reg_we;
  assign out_mem_read      = r_dec.mem_read;
  assign out_mem_write     = r_dec.mem_write;
  assign out_funct3        = r_dec.funct3;
  assign out_br_kind       = r_dec.br_kind;
  assign out_br_invert     = r_dec.br_invert;
  assign out_jump          = r_dec.jump;

endmodule
